// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues requests to an
// in-order variable-latency instruction memory, and buffers returned words
// in a prefetch FIFO that presents one {addr, instr} per cycle to IF/ID.
// Credits (buffered + in flight) never exceed DEPTH, so the FIFO cannot
// overflow. After a redirect, words still in flight are counted in
// discard_q and dropped as they return.
module fetch_prefetch_unit #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] ADDR_LIMIT = 32'd128,
  parameter logic [31:0] RESET_PC   = 32'd0
) (
  input  logic        clk,
  input  logic        rst_,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        deq_en,
  input  logic        halt,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_addr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  // Control state (reset)
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  // Datapath storage (not reset; qualified by the control state above)
  logic [31:0] fifo_addr_q [DEPTH];
  logic [31:0] fifo_word_q [DEPTH];
  logic [31:0] tag_addr_q  [DEPTH];

  logic credit_ok, gnt_fire, rsp_fire, drop, push, pop;

  assign credit_ok = ({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_C;
  // Gated by rst_ so that no request is visible while reset is held.
  assign imem_req  = rst_ & ~flush & ~halt & (fetch_pc_q < ADDR_LIMIT) & credit_ok;
  assign imem_addr = fetch_pc_q;
  assign gnt_fire  = imem_req & imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire  = imem_rvalid & (outstanding_q != '0);
  assign drop      = flush | (discard_q != '0);
  assign push      = rsp_fire & ~drop;
  assign pop       = deq_en & instr_valid & ~halt & ~flush;

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? fifo_word_q[rd_ptr_q] : 32'd0;
  assign instr_addr  = instr_valid ? fifo_addr_q[rd_ptr_q] : 32'd0;

  // Next-state for PC, credits, discard count and queue pointers
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(rsp_fire);
    discard_d     = discard_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    tag_wr_d      = gnt_fire ? tag_wr_q + 1'b1 : tag_wr_q;
    tag_rd_d      = rsp_fire ? tag_rd_q + 1'b1 : tag_rd_q;
    if (flush) begin
      fetch_pc_d = flush_target;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      // Everything still in flight after this cycle belongs to the old path.
      discard_d  = outstanding_d;
    end else begin
      if (gnt_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      if (rsp_fire && (discard_q != '0)) discard_d = discard_q - 1'b1;
    end
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_) begin
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
    end
  end

  // Address tag capture on grant and FIFO write on accepted response
  always_ff @(posedge clk) begin
    if (gnt_fire) tag_addr_q[tag_wr_q] <= fetch_pc_q;
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= tag_addr_q[tag_rd_q];
      fifo_word_q[wr_ptr_q] <= imem_rdata;
    end
  end

  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rst_)
    imem_rvalid |-> (outstanding_q != '0));

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Instruction-fetch front end sitting directly upstream of the IF/ID state register. Owns the fetch PC and issues requests to an external instruction memory with a request/grant handshake and in-order, variable-latency responses. Responses are buffered in a small prefetch FIFO that presents one instruction per cycle to IF/ID. Supports redirect/flush on a taken branch or jump, stall from hazard detection, halt, and an instruction-address limit.

Parameters:
DEPTH, 4, prefetch FIFO entries and maximum in-flight plus buffered fetches (power of 2, ≥2)
ADDR_LIMIT, 128, byte address at which fetching stops (addresses ≥ ADDR_LIMIT are never requested)
RESET_PC, 0, fetch PC after reset (word aligned)

Ports:
clk  in  1  system clock
rst_  in  1  reset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch byte address (= fetch_pc)
imem_gnt  in  1  request accepted this cycle (meaningful only while imem_req=1)
imem_rvalid  in  1  response valid; responses return in request order, ≥1 cycle after grant
imem_rdata  in  32  response instruction word
flush  in  1  redirect: taken branch or jump resolved in MEM
flush_target  in  32  new fetch PC, sampled when flush=1
deq_en  in  1  IF/ID accepts the head instruction this cycle (hazard-unit update enable)
halt  in  1  halt detected; freeze all fetch state
instr_valid  out  1  head entry valid
instr  out  32  head instruction; 32'd0 when instr_valid=0
instr_addr  out  32  head instruction byte address; 0 when instr_valid=0

Behaviour:
- Reset: one clock, synchronous, active-low: rst_=0 sampled on a rising clk edge resets all state. Reset-mid-operation drops everything in flight.
- Reset state: fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0; imem_req=0; instr_valid=0; instr=0; instr_addr=0.
- State: fetch_pc; FIFO of {addr, word}; outstanding count (0..DEPTH); discard count (0..outstanding).
- imem_req = !flush & !halt & (fetch_pc < ADDR_LIMIT) & (fifo_count + outstanding < DEPTH). imem_req is combinational from registered state plus flush/halt.
- Grant (imem_req & imem_gnt):
  - fetch_pc += 4; wraps modulo 2^32, unreachable below ADDR_LIMIT.
  - outstanding += 1.
  - The request's address is queued in an internal in-order address tag of DEPTH entries.
- Response (imem_rvalid):
  - outstanding -= 1 and the tag pops.
  - If discard>0 (or flush=1 this cycle), the word is dropped and discard decrements when nonzero.
  - Otherwise {tag, imem_rdata} is written to the FIFO tail.
  - rvalid with outstanding=0 is a protocol error: ignore the response; assertion fires in simulation.
- FIFO:
  - Write is registered; a word is visible at the head no earlier than the cycle after its rvalid. No bypass.
  - Pop occurs on deq_en & instr_valid. Simultaneous push and pop is legal at any occupancy.
  - The credit rule guarantees no overflow.
  - Empty FIFO outputs instr=0 (NOP) with instr_valid=0; deq_en while empty is ignored.
- Flush (priority over everything except reset):
  - FIFO cleared; fetch_pc <= flush_target.
  - discard <= outstanding after this cycle's response accounting.
  - No request is issued in the flush cycle.
  - Requests to the new target may start the next cycle, while discards drain.
- Halt (when not flushing):
  - No requests issued; FIFO, fetch_pc and outputs hold; no pops.
  - Responses for already-granted requests are still accepted into the FIFO, or discarded per the discard count.
- Address limit: once fetch_pc ≥ ADDR_LIMIT, requests stop. The FIFO drains normally, then instr_valid=0, instr=0. A flush to a legal target resumes fetching.
- Throughput: with zero stalls and a 1-cycle memory, sustains one instruction per cycle after a 2-cycle start-up from reset release.

Test Plan:
- Reset release, imem_gnt=1 always, 1-cycle rvalid, deq_en=1 → imem_addr 0,4,8,… on consecutive cycles; instr_valid first high 2 cycles after the first grant; instr_addr sequence 0,4,8 with matching data, no gaps.
- deq_en=0 held, memory always grants → exactly DEPTH=4 grants (addresses 0..12), then imem_req=0; raising deq_en pops 0,4,8,12 in order and requests resume at 16.
- 3-cycle memory latency, 3 grants outstanding, flush=1 with flush_target=0x40 → FIFO empty next cycle; the 3 late responses are dropped; first delivered instr_addr=0x40.
- flush coincident with rvalid and deq_en → the response is dropped, no pop is counted, fetch restarts at flush_target, and outstanding/discard totals match the grants issued.
- Sequential run up to ADDR_LIMIT=128 → last requested address 124; after the FIFO drains, instr_valid=0 and instr=0; a flush to 0x10 resumes fetching at 0x10.
- halt=1 mid-stream with 2 outstanding → no new imem_req; both responses enter the FIFO; outputs frozen. rst_=0 for one cycle then → all outputs at their reset values and imem_addr=RESET_PC.
